// File: rtl/bg_pkg.sv
// Shared definitions for the background scroll scheduler: register map,
// scheduler modes and FSM state encoding.
package bg_pkg;

    localparam logic [5:0] ADDR_SCHED  = 6'h04;
    localparam logic [5:0] ADDR_SPEED0 = 6'h08;
    localparam logic [5:0] ADDR_IRQ    = 6'h14;
    localparam logic [5:0] ADDR_STATUS = 6'h18;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_FIXED   = 2'd1;
    localparam logic [1:0] MODE_AUTO    = 2'd2;
    localparam logic [1:0] MODE_OFF_ALT = 2'd3;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    // Speed registers sit on consecutive word addresses.
    function automatic logic [5:0] speed_addr(input int k);
        return ADDR_SPEED0 + 6'(4 * k);
    endfunction

    function automatic logic mode_is_off(input logic [1:0] m);
        return (m == MODE_OFF) || (m == MODE_OFF_ALT);
    endfunction

endpackage

// File: rtl/scroll_accum.sv
// One layer's sub-pixel horizontal scroll accumulator; advances by the signed
// speed once per frame edge and exposes the integer part as the offset.
module scroll_accum #(
    parameter int OFS_W  = 10,
    parameter int FRAC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       speed,
    input  logic             fe,
    output logic [OFS_W-1:0] offset
);

    localparam int ACC_W = OFS_W + FRAC_W;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // Modular add of the sign-extended speed wraps in both directions.
    always_comb begin
        acc_d = acc_q;
        if (fe) begin
            acc_d = acc_q + {{(ACC_W-8){speed[7]}}, speed};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign offset = acc_q[ACC_W-1:FRAC_W];

endmodule

// File: rtl/bg_scroll_scheduler.sv
// Per-frame sequencer for the scrolling background layers: register file,
// per-layer scroll accumulators, visible-layer FSM and frame interrupt.
module bg_scroll_scheduler
    import bg_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int OFS_W      = 10,
    parameter int FRAC_W     = 4,
    parameter int DWELL_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [5:0]                  address,
    input  logic [31:0]                 data_in,
    input  logic [1:0]                  data_write_n,
    output logic [31:0]                 data_out,
    input  logic                        vsync,
    output logic [NUM_LAYERS-1:0]       layer_en,
    output logic [NUM_LAYERS*OFS_W-1:0] scroll_x,
    output logic                        frame_irq
);

    logic                           vsync_q;
    logic                           fe;
    logic                           wr;
    logic                           wr_sched;
    logic                           unused_bits;

    logic [1:0]                     mode_q, mode_d;
    logic [1:0]                     fixed_q, fixed_d;
    logic                           irq_en_q, irq_en_d;
    logic [DWELL_W-1:0]             dwell_q, dwell_d;
    logic [NUM_LAYERS-1:0][7:0]     speed_q, speed_d;
    logic                           irq_q, irq_d;

    state_e                         state_q, state_d;
    logic [1:0]                     cur_q, cur_d;
    logic [DWELL_W-1:0]             cnt_q, cnt_d;

    logic                           fixed_ok;
    logic [DWELL_W-1:0]             dwell_max;
    logic [DWELL_W:0]               cnt_inc;
    logic [1:0]                     next_layer;

    assign fe          = vsync & ~vsync_q;
    assign wr          = (data_write_n != 2'b11);
    assign wr_sched    = wr && (address == ADDR_SCHED);
    assign unused_bits = ^{data_in[31:16], data_in[7:5]};

    assign fixed_ok   = (32'(fixed_q) < NUM_LAYERS);
    assign dwell_max  = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
    assign cnt_inc    = {1'b0, cnt_q} + (DWELL_W+1)'(1);
    assign next_layer = (cur_q == 2'(NUM_LAYERS - 1)) ? 2'd0 : cur_q + 2'd1;

    always_comb begin
        mode_d   = mode_q;
        fixed_d  = fixed_q;
        irq_en_d = irq_en_q;
        dwell_d  = dwell_q;
        speed_d  = speed_q;
        if (wr_sched) begin
            mode_d   = data_in[1:0];
            fixed_d  = data_in[3:2];
            irq_en_d = data_in[4];
            dwell_d  = data_in[8 +: DWELL_W];
        end
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (wr && (address == speed_addr(k))) begin
                speed_d[k] = data_in[7:0];
            end
        end
    end

    // A set from the frame edge wins over a simultaneous clear.
    always_comb begin
        irq_d = irq_q;
        if (wr && (address == ADDR_IRQ) && data_in[0]) begin
            irq_d = 1'b0;
        end
        if (fe && irq_en_q) begin
            irq_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        if (fe) begin
            case (state_q)
                ST_OFF: begin
                    if (mode_q == MODE_FIXED && fixed_ok) begin
                        state_d = ST_SHOW;
                        cur_d   = fixed_q;
                        cnt_d   = '0;
                    end else if (mode_q == MODE_AUTO) begin
                        state_d = ST_SHOW;
                        cur_d   = 2'd0;
                        cnt_d   = '0;
                    end
                end
                ST_SHOW: begin
                    if (mode_q == MODE_FIXED) begin
                        cnt_d = '0;
                        if (fixed_ok) begin
                            cur_d = fixed_q;
                        end else begin
                            state_d = ST_OFF;
                        end
                    end else if (mode_q == MODE_AUTO) begin
                        if (cnt_inc >= {1'b0, dwell_max}) begin
                            state_d = ST_BLANK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc[DWELL_W-1:0];
                        end
                    end else begin
                        state_d = ST_OFF;
                    end
                end
                ST_BLANK: begin
                    cnt_d = '0;
                    if (mode_q == MODE_AUTO) begin
                        state_d = ST_SHOW;
                        cur_d   = next_layer;
                    end else if (mode_q == MODE_FIXED && fixed_ok) begin
                        state_d = ST_SHOW;
                        cur_d   = fixed_q;
                    end else begin
                        state_d = ST_OFF;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
        // Switching off takes effect immediately rather than at the next frame.
        if (wr_sched && mode_is_off(data_in[1:0])) begin
            state_d = ST_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            mode_q   <= MODE_OFF;
            fixed_q  <= 2'd0;
            irq_en_q <= 1'b0;
            dwell_q  <= '0;
            speed_q  <= '0;
            irq_q    <= 1'b0;
            state_q  <= ST_OFF;
            cur_q    <= 2'd0;
            cnt_q    <= '0;
        end else begin
            vsync_q  <= vsync;
            mode_q   <= mode_d;
            fixed_q  <= fixed_d;
            irq_en_q <= irq_en_d;
            dwell_q  <= dwell_d;
            speed_q  <= speed_d;
            irq_q    <= irq_d;
            state_q  <= state_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        scroll_accum #(
            .OFS_W  (OFS_W),
            .FRAC_W (FRAC_W)
        ) u_accum (
            .clk    (clk),
            .rst_n  (rst_n),
            .speed  (speed_q[k]),
            .fe     (fe),
            .offset (scroll_x[k*OFS_W +: OFS_W])
        );
    end

    always_comb begin
        data_out = '0;
        case (address)
            ADDR_SCHED: begin
                data_out[1:0]          = mode_q;
                data_out[3:2]          = fixed_q;
                data_out[4]            = irq_en_q;
                data_out[8 +: DWELL_W] = dwell_q;
            end
            ADDR_IRQ:    data_out[0]   = irq_q;
            ADDR_STATUS: data_out[3:0] = {cur_q, state_q};
            default: ;
        endcase
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (address == speed_addr(k)) begin
                data_out[7:0] = speed_q[k];
            end
        end
    end

    assign layer_en  = (state_q == ST_SHOW) ? (NUM_LAYERS'(1) << cur_q) : '0;
    assign frame_irq = irq_q;

endmodule

// File: tb/tb_bg_scroll_scheduler.sv
// Directed-plus-random bench for bg_scroll_scheduler against a frame-level
// reference model (accumulator arithmetic, closed-form auto rotation).
module tb_bg_scroll_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  address = 6'h00;
    logic [31:0] data_in = 32'h0;
    logic [1:0]  data_write_n = 2'b11;
    logic [31:0] data_out;
    logic        vsync = 1'b0;
    logic [2:0]  layer_en;
    logic [29:0] scroll_x;
    logic        frame_irq;

    int checks = 0;
    int errors = 0;

    int         m_acc [3];
    logic [7:0] m_speed [3];
    logic       m_irq;
    logic       m_irq_en;

    bg_scroll_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_out     (data_out),
        .vsync        (vsync),
        .layer_en     (layer_en),
        .scroll_x     (scroll_x),
        .frame_irq    (frame_irq)
    );

    always #8 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k]   = 0;
            m_speed[k] = 8'h00;
        end
        m_irq    = 1'b0;
        m_irq_en = 1'b0;
    endtask

    task automatic model_fe();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = (m_acc[k] + int'($signed(m_speed[k]))) & 32'h3FFF;
        end
        if (m_irq_en) m_irq = 1'b1;
    endtask

    task automatic model_write(input logic [5:0] a, input logic [31:0] d);
        for (int k = 0; k < 3; k++) begin
            if (a == 6'(8 + 4 * k)) m_speed[k] = d[7:0];
        end
        if (a == 6'h04) m_irq_en = d[4];
        if (a == 6'h14 && d[0]) m_irq = 1'b0;
    endtask

    function automatic logic [29:0] exp_scroll();
        logic [29:0] e;
        int a;
        for (int k = 0; k < 3; k++) begin
            a = m_acc[k];
            e[k*10 +: 10] = a[13:4];
        end
        return e;
    endfunction

    // Auto rotation, frame n >= 1 after leaving OFF: each layer shows for
    // max(dwell,1) frames followed by one blank frame.
    function automatic logic [2:0] auto_en(input int n, input int dwell);
        int d = (dwell == 0) ? 1 : dwell;
        int p = (n - 1) % (d + 1);
        int l = ((n - 1) / (d + 1)) % 3;
        return (p < d) ? 3'(1 << l) : 3'b000;
    endfunction

    function automatic logic [31:0] auto_status(input int n, input int dwell);
        int d = (dwell == 0) ? 1 : dwell;
        int p = (n - 1) % (d + 1);
        int l = ((n - 1) / (d + 1)) % 3;
        return 32'((l << 2) | ((p < d) ? 1 : 2));
    endfunction

    task automatic frame();
        @(negedge clk) vsync = 1'b1;
        @(posedge clk);
        model_fe();
        @(negedge clk);
        @(negedge clk) vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a;
        data_in = d;
        data_write_n = 2'b10;
        @(posedge clk);
        model_write(a, d);
        #1 data_write_n = 2'b11;
    endtask

    // Register write landing on the same clock edge as the frame edge.
    task automatic fe_write(input logic [5:0] a, input logic [31:0] d);
        logic en;
        @(negedge clk);
        vsync = 1'b1;
        address = a;
        data_in = d;
        data_write_n = 2'b00;
        @(posedge clk);
        en = m_irq_en;
        model_fe();
        model_write(a, d);
        if (en) m_irq = 1'b1;
        #1 data_write_n = 2'b11;
        @(negedge clk);
        @(negedge clk) vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
        @(negedge clk) address = a;
        #1 check(tag, data_out, exp);
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] exp_en);
        check({tag, "_layer_en"}, 32'(layer_en), 32'(exp_en));
        check({tag, "_scroll_x"}, 32'(scroll_x), 32'(exp_scroll()));
        check({tag, "_irq"}, 32'(frame_irq), 32'(m_irq));
    endtask

    logic [2:0]  tbl [10];
    logic [7:0]  s;
    int          dw [4];
    int          n;

    initial begin
        tbl = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state and idle frames
        @(negedge clk);
        check_outputs("reset", 3'b000);
        read_check("reset_status", 6'h18, 32'h0);
        read_check("reset_sched", 6'h04, 32'h0);
        repeat (3) frame();
        check_outputs("idle", 3'b000);
        read_check("idle_status", 6'h18, 32'h0);
        read_check("unmapped", 6'h3C, 32'h0);

        // Scroll accumulators
        s = 8'($urandom_range(0, 255));
        write_reg(6'h08, 32'h10);
        write_reg(6'h0C, 32'hF8);
        write_reg(6'h10, {24'h0, s});
        read_check("rd_speed0", 6'h08, 32'h10);
        read_check("rd_speed1", 6'h0C, 32'hF8);
        read_check("rd_speed2", 6'h10, {24'h0, s});
        repeat (4) frame();
        check("x0_4frames", 32'(scroll_x[9:0]), 32'd4);
        check("x1_4frames", 32'(scroll_x[19:10]), 32'd1022);
        check_outputs("scroll4", 3'b000);
        repeat (1026) frame();
        check("x0_wrap", 32'(scroll_x[9:0]), 32'd6);
        check_outputs("scroll1030", 3'b000);
        repeat (3) begin
            for (int k = 0; k < 3; k++) write_reg(6'(8 + 4 * k), $urandom);
            n = $urandom_range(1, 40);
            repeat (n) frame();
            check_outputs("scroll_rand", 3'b000);
        end

        // Auto rotation, dwell 2 against the literal sequence
        write_reg(6'h04, 32'h0202);
        check("auto_wait_fe", 32'(layer_en), 32'h0);
        read_check("rd_sched", 6'h04, 32'h0202);
        for (int i = 0; i < 10; i++) begin
            frame();
            check("auto_seq", 32'(layer_en), 32'(tbl[i]));
            read_check("auto_status", 6'h18, auto_status(i + 1, 2));
        end

        // Auto rotation with other dwell values, including 0 (acts as 1)
        dw = '{0, 1, 3, int'($urandom_range(1, 5))};
        for (int j = 0; j < 4; j++) begin
            write_reg(6'h04, 32'h0);
            check("auto_off", 32'(layer_en), 32'h0);
            write_reg(6'h04, 32'(dw[j] << 8) | 32'h2);
            for (int i = 1; i <= 3 * (dw[j] + 1) + 1; i++) begin
                frame();
                check("auto_dwell", 32'(layer_en), 32'(auto_en(i, dw[j])));
            end
        end
        check_outputs("auto_end", layer_en === 3'bxxx ? 3'b000 : auto_en(3 * (dw[3] + 1) + 1, dw[3]));

        // Fixed layer and frame interrupt
        write_reg(6'h04, 32'h0);
        write_reg(6'h04, 32'h15);
        check_outputs("fixed_pre", 3'b000);
        frame();
        check_outputs("fixed1", 3'b010);
        write_reg(6'h14, 32'h1);
        check("irq_clear", 32'(frame_irq), 32'h0);
        fe_write(6'h14, 32'h1);
        check("irq_set_beats_clear", 32'(frame_irq), 32'h1);
        read_check("rd_irq", 6'h14, 32'(m_irq));
        write_reg(6'h04, 32'h19);
        frame();
        check_outputs("fixed2", 3'b100);
        write_reg(6'h04, 32'h1D);
        frame();
        check_outputs("fixed_invalid", 3'b000);
        write_reg(6'h04, 32'h0);
        write_reg(6'h14, 32'h1);
        frame();
        check_outputs("irq_disabled", 3'b000);

        // Immediate OFF and speed write coincident with frame edge
        write_reg(6'h04, 32'h0302);
        frame();
        check("auto_start", 32'(layer_en), 32'h1);
        write_reg(6'h04, 32'h0);
        check("off_next_cycle", 32'(layer_en), 32'h0);
        read_check("off_state", 6'h18, 32'(data_out[3:2]) << 2);
        check("off_state_bits", 32'(data_out[1:0]), 32'h0);
        frame();
        check_outputs("off_frame", 3'b000);
        fe_write(6'h08, {24'h0, m_speed[0] ^ 8'h55});
        check_outputs("speed_collide", 3'b000);
        frame();
        check_outputs("speed_after", 3'b000);

        // Reset mid-frame in auto mode
        write_reg(6'h04, 32'h0112);
        repeat (3) frame();
        check_outputs("pre_reset", auto_en(3, 1));
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check_outputs("mid_reset", 3'b000);
        check("mid_reset_status", data_out & 32'h0, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        read_check("post_reset_status", 6'h18, 32'h0);
        read_check("post_reset_speed0", 6'h08, 32'h0);
        read_check("post_reset_sched", 6'h04, 32'h0);
        write_reg(6'h04, 32'h0002);
        frame();
        check_outputs("restart1", 3'b001);
        frame();
        check_outputs("restart2", auto_en(2, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
